pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage forwarding core. Generates per-stage enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Resolves load-use hazards, taken-branch/jump redirects and multi-cycle data-memory waits, with a watchdog on memory waits. It sits beside the datapath, sampling ID/EX and EX/MEM fields and driving only register controls.

## Interface
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before forced release (≥2)
- CNT_W, 32: width of performance counters
- clk_i  in  1  core clock
- rst_i  in  1  reset. One clock; reset is asynchronous and active-low.
- id_rs1_addr_i / id_rs2_addr_i  in  5  source registers of the instruction in ID
- id_rs1_used_i / id_rs2_used_i  in  1  the ID instruction reads rs1 / rs2
- ex_rd_addr_i  in  5  rd of the instruction in EX (ID/EX output)
- ex_rd_wren_i, ex_is_load_i  in  1  EX instruction writes rd / is a load
- ex_redirect_i  in  1  EX resolved a taken branch or jump
- mem_req_i  in  1  MEM stage holds a load/store access
- mem_ack_i  in  1  data memory completes the access this cycle
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1  register enables
- if_id_flush_o, id_ex_flush_o  out  1  synchronous bubble insert, dominates enable in the register
- mem_err_o  out  1  sticky memory-timeout flag
- stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters

## Operation
- FSM states: RUN, MEM_WAIT.
  - RUN→MEM_WAIT when mem_req_i && !mem_ack_i.
  - MEM_WAIT→RUN on mem_ack_i, or when wait_cnt == MEM_TIMEOUT-1.
  - Zero-wait access: req and ack in the same cycle keeps the FSM in RUN.
- mem_stall = mem_req_i && !mem_ack_i && !timeout_release.
  - On mem_stall, all enables are 0 and all flushes are 0. This applies whole-pipe in both states.
- timeout_release: state==MEM_WAIT && wait_cnt==MEM_TIMEOUT-1 && !mem_ack_i.
  - Treated as an ack: the pipe advances and mem_err_o is set (sticky until reset).
- wait_cnt: cleared in RUN, increments each MEM_WAIT cycle, never exceeds MEM_TIMEOUT-1.
- load_use = ex_is_load_i && ex_rd_wren_i && ex_rd_addr_i≠0 && ((rs1_used && rs1==rd) || (rs2_used && rs2==rd)).
- Priority: mem_stall > ex_redirect_i > load_use > normal.
  - Redirect: all enables 1, if_id_flush_o=1, id_ex_flush_o=1.
  - Load-use: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, ex_mem_en_o=1, mem_wb_en_o=1.
  - Normal: all enables 1, flushes 0.
- A redirect during mem_stall is deferred, not dropped. The EX register is frozen, so ex_redirect_i stays high and takes effect in the release cycle.
- Redirect coinciding with load-use: redirect only. No extra bubble; the ID instruction is squashed anyway.

## Timing
- All enable/flush outputs are combinational from current inputs and state, with zero latency. Pipeline registers act on the next clk_i edge.
- While rst_i is low: state=RUN, wait_cnt=0, mem_err_o=0, counters=0. All enables are forced 0 and flushes 0.
- Reset asserted mid-MEM_WAIT aborts the wait immediately (asynchronous). After deassertion the FSM is in RUN.
- Load-use stall lasts exactly 1 cycle: the bubble clears ex_is_load_i on the next edge.
- Maximum memory stall is MEM_TIMEOUT cycles, including the entry cycle.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt_o increments on every cycle with mem_stall or load_use.
  - flush_cnt_o increments on every applied redirect (not deferred cycles).
  - Both saturate at 2^CNT_W-1.
- HAZARD_PERF_EN undefined: counter registers are not built; both ports are driven constant 0.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - typedef enum hz_state_e {RUN, MEM_WAIT}
  - packed struct pipe_ctrl_t grouping the five enables and two flushes
  - constant REG_X0 = 5'd0
- Sub-module load_use_detect: purely combinational rs/rd compare producing load_use. It is reused by the forwarding unit's tests.

## Test plan
- Independent ALU ops (mem_req_i=0): all enables 1 and flushes 0 every cycle; counters stay 0.
- lw x5 in EX, ID reads rs1=x5: one cycle with pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1. Next cycle normal. stall_cnt_o=1. Repeat with rd=x0: no stall.
- mem_req_i=1, ack after 3 cycles: enables 0 for 3 cycles, FSM in MEM_WAIT. Release on the ack cycle with enables 1.
- ex_redirect_i=1 during a 2-cycle memory wait: flushes 0 while stalled. if_id_flush_o and id_ex_flush_o are 1 in the release cycle. flush_cnt_o=1.
- MEM_TIMEOUT=4, ack never arrives: forced release after 4 stall cycles. mem_err_o=1 and held; asserting rst_i low clears it.
- Redirect and load-use in the same cycle: pc_en_o=1 with both flushes 1; stall_cnt_o unchanged.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states, the grouped
// per-stage register controls and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam pipe_ctrl_t CTRL_HOLD = '{default: 1'b0};
  localparam pipe_ctrl_t CTRL_RUN  = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                       ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                       if_id_flush: 1'b0, id_ex_flush: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use check: the EX load writes a register the ID instruction reads.
// x0 is never a hazard since writes to it are discarded.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd_addr,
  input  logic       rd_wren,
  input  logic       is_load,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = rs1_used && (rs1_addr == rd_addr);
  assign rs2_hit  = rs2_used && (rs2_addr == rd_addr);
  assign load_use = is_load && rd_wren && (rd_addr != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush sequencing for load-use, redirect and memory-wait hazards,
// with a memory-wait watchdog. Optional perf counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wren_i,
  input  logic             ex_is_load_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int             WC_W   = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT - 1);

  hz_state_e       state;
  hz_state_e       state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic            load_use;
  logic            timeout_release;
  logic            mem_stall;
  pipe_ctrl_t      ctrl;

  load_use_detect u_load_use_detect (
    .rs1_addr (id_rs1_addr_i),
    .rs2_addr (id_rs2_addr_i),
    .rs1_used (id_rs1_used_i),
    .rs2_used (id_rs2_used_i),
    .rd_addr  (ex_rd_addr_i),
    .rd_wren  (ex_rd_wren_i),
    .is_load  (ex_is_load_i),
    .load_use (load_use)
  );

  // A watchdog expiry is treated exactly like an ack so the pipe drains.
  assign timeout_release = (state == MEM_WAIT) && (wait_cnt == WC_MAX) && !mem_ack_i;
  assign mem_stall       = mem_req_i && !mem_ack_i && !timeout_release;

  always_comb begin
    state_nxt = state;
    ctrl      = CTRL_RUN;
    case (state)
      RUN:      if (mem_req_i && !mem_ack_i) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ack_i || (wait_cnt == WC_MAX)) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
    // EX is frozen during a stall, so a pending redirect re-presents on release.
    if (!rst_i || mem_stall) begin
      ctrl = CTRL_HOLD;
    end else if (ex_redirect_i) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_en    = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= ((state == MEM_WAIT) && (state_nxt == MEM_WAIT)) ? wait_cnt + 1'b1 : '0;
      if (timeout_release) mem_err_o <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_inc;
  logic flush_inc;

  // Stall counts cycles the front end is held; a redirect overriding load-use is not a stall.
  assign stall_inc = mem_stall || (!ex_redirect_i && load_use);
  assign flush_inc = !mem_stall && ex_redirect_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_inc && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_inc && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  assign pc_en_o       = ctrl.pc_en;
  assign if_id_en_o    = ctrl.if_id_en;
  assign id_ex_en_o    = ctrl.id_ex_en;
  assign ex_mem_en_o   = ctrl.ex_mem_en;
  assign mem_wb_en_o   = ctrl.mem_wb_en;
  assign if_id_flush_o = ctrl.if_id_flush;
  assign id_ex_flush_o = ctrl.id_ex_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); counter expectations follow HAZARD_PERF_EN.
module tb_pipe_hazard_ctrl;

  localparam int MT = 4;
  localparam int CW = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] C_HOLD = 7'b0000000;
  localparam logic [6:0] C_RUN  = 7'b1111100;
  localparam logic [6:0] C_REDIR = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    rs1, rs2, rd;
  logic          rs1_used, rs2_used, rd_wren, is_load, redirect, mem_req, mem_ack;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic          mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_rs1_addr_i (rs1),
    .id_rs2_addr_i (rs2),
    .id_rs1_used_i (rs1_used),
    .id_rs2_used_i (rs2_used),
    .ex_rd_addr_i  (rd),
    .ex_rd_wren_i  (rd_wren),
    .ex_is_load_i  (is_load),
    .ex_redirect_i (redirect),
    .mem_req_i     (mem_req),
    .mem_ack_i     (mem_ack),
    .pc_en_o       (pc_en),
    .if_id_en_o    (if_id_en),
    .id_ex_en_o    (id_ex_en),
    .ex_mem_en_o   (ex_mem_en),
    .mem_wb_en_o   (mem_wb_en),
    .if_id_flush_o (if_id_flush),
    .id_ex_flush_o (id_ex_flush),
    .mem_err_o     (mem_err),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_stall_cnt"}, stall_cnt, PERF ? 32'(exp_stall) : 32'd0);
    chk({tag, "_flush_cnt"}, flush_cnt, PERF ? 32'(exp_flush) : 32'd0);
  endtask

  // Advance to the next negedge, then let combinational outputs settle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
    rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
  endtask

  task automatic set_ex(input logic [4:0] d, input logic w, input logic ld, input logic rdr);
    rd = d; rd_wren = w; is_load = ld; redirect = rdr;
  endtask

  initial begin
    set_id(5'd0, 1'b0, 5'd0, 1'b0);
    set_ex(5'd0, 1'b0, 1'b0, 1'b0);
    mem_req = 1'b0; mem_ack = 1'b0;

    // Reset: everything held, no flags.
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(C_HOLD));
    chk("rst_err", 32'(mem_err), 32'd0);
    chk_cnt("rst");
    next_cycle();
    rst = 1'b1;
    #1;

    // Independent ALU ops.
    set_id(5'd1, 1'b1, 5'd2, 1'b1); set_ex(5'd3, 1'b1, 1'b0, 1'b0); #1;
    chk("alu0", 32'(ctrl), 32'(C_RUN));
    next_cycle();
    set_id(5'd3, 1'b1, 5'd4, 1'b1); set_ex(5'd3, 1'b1, 1'b0, 1'b0); #1;
    chk("alu1_fwd", 32'(ctrl), 32'(C_RUN));
    next_cycle();
    chk_cnt("alu");

    // lw x5 in EX, ID reads x5 through rs1.
    set_id(5'd5, 1'b1, 5'd6, 1'b1); set_ex(5'd5, 1'b1, 1'b1, 1'b0); #1;
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_if_id_en", 32'(if_id_en), 32'd0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    chk("lu_ex_mem_en", 32'(ex_mem_en), 32'd1);
    chk("lu_mem_wb_en", 32'(mem_wb_en), 32'd1);
    chk("lu_if_id_flush", 32'(if_id_flush), 32'd0);
    exp_stall++;
    next_cycle();
    set_ex(5'd0, 1'b0, 1'b0, 1'b0); #1;
    chk("lu_after", 32'(ctrl), 32'(C_RUN));
    chk_cnt("lu");
    next_cycle();

    // lw into x0 never stalls.
    set_id(5'd0, 1'b1, 5'd0, 1'b1); set_ex(5'd0, 1'b1, 1'b1, 1'b0); #1;
    chk("lu_x0", 32'(ctrl), 32'(C_RUN));
    next_cycle();
    // Match on rs2 but rs2 unused: no stall.
    set_id(5'd1, 1'b1, 5'd9, 1'b0); set_ex(5'd9, 1'b1, 1'b1, 1'b0); #1;
    chk("lu_rs2_unused", 32'(ctrl), 32'(C_RUN));
    next_cycle();
    // Match on rs2 used: stall.
    set_id(5'd1, 1'b1, 5'd9, 1'b1); #1;
    chk("lu_rs2", 32'(ctrl), 32'b0011101);
    exp_stall++;
    next_cycle();
    set_ex(5'd0, 1'b0, 1'b0, 1'b0); #1;
    chk_cnt("lu_rs2");

    // Memory access acked after 3 wait cycles.
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_stall%0d", i), 32'(ctrl), 32'(C_HOLD));
      exp_stall++;
      next_cycle();
    end
    mem_ack = 1'b1; #1;
    chk("mw_release", 32'(ctrl), 32'(C_RUN));
    next_cycle();
    mem_req = 1'b0; mem_ack = 1'b0; #1;
    chk("mw_after", 32'(ctrl), 32'(C_RUN));
    chk_cnt("mw");
    next_cycle();

    // Redirect deferred across a 2-cycle wait.
    mem_req = 1'b1; redirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("rd_stall%0d", i), 32'(ctrl), 32'(C_HOLD));
      exp_stall++;
      next_cycle();
    end
    mem_ack = 1'b1; #1;
    chk("rd_release", 32'(ctrl), 32'(C_REDIR));
    exp_flush++;
    next_cycle();
    mem_req = 1'b0; mem_ack = 1'b0; redirect = 1'b0; #1;
    chk_cnt("rd");
    next_cycle();

    // Watchdog: ack never arrives; 4 stall cycles then forced release.
    mem_req = 1'b1;
    for (int i = 0; i < MT; i++) begin
      #1;
      chk($sformatf("to_stall%0d", i), 32'(ctrl), 32'(C_HOLD));
      exp_stall++;
      next_cycle();
    end
    #1;
    chk("to_release", 32'(ctrl), 32'(C_RUN));
    chk("to_err_pre", 32'(mem_err), 32'd0);
    next_cycle();
    mem_req = 1'b0; #1;
    chk("to_err_set", 32'(mem_err), 32'd1);
    next_cycle(); next_cycle(); #1;
    chk("to_err_held", 32'(mem_err), 32'd1);
    chk_cnt("to");

    // Redirect and load-use together: redirect wins, no stall counted.
    set_id(5'd7, 1'b1, 5'd0, 1'b0); set_ex(5'd7, 1'b1, 1'b1, 1'b1); #1;
    chk("rdlu_ctrl", 32'(ctrl), 32'(C_REDIR));
    exp_flush++;
    next_cycle();
    set_ex(5'd0, 1'b0, 1'b0, 1'b0); #1;
    chk_cnt("rdlu");

    // Reset in the middle of a memory wait.
    mem_req = 1'b1;
    next_cycle(); next_cycle();
    rst = 1'b0; #1;
    chk("mrst_ctrl", 32'(ctrl), 32'(C_HOLD));
    chk("mrst_err", 32'(mem_err), 32'd0);
    exp_stall = 0; exp_flush = 0;
    chk_cnt("mrst");
    next_cycle();
    rst = 1'b1; mem_req = 1'b0; #1;
    chk("mrst_run", 32'(ctrl), 32'(C_RUN));
    next_cycle();
    // Zero-wait access stays in RUN; a fresh wait gets the full watchdog budget.
    mem_req = 1'b1; mem_ack = 1'b1; #1;
    chk("zw_ctrl", 32'(ctrl), 32'(C_RUN));
    next_cycle();
    mem_ack = 1'b0;
    for (int i = 0; i < MT; i++) begin
      #1;
      chk($sformatf("zw_stall%0d", i), 32'(ctrl), 32'(C_HOLD));
      next_cycle();
    end
    #1;
    chk("zw_release", 32'(ctrl), 32'(C_RUN));
    next_cycle();
    mem_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
